sub_serial_16b: RTL and testbench

SUB_SERIAL_16B -- requirements
Module: sub_serial_16b

---
 rtl/sub_serial_16b.sv | 124 ++++++++++++
 tb/tb_sub_serial_16b.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial_16b.sv
// Serial 16-bit subtractor: one nibble per cycle, LSB first, with a 4-bit borrow-lookahead slice.
// Define SUB_CLAMP_EN to saturate the result at zero when the final borrow-out is set.
module sub_serial_16b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] diff,
    output logic        bout,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        bin_q, bin_d;
    logic [1:0]  idx_q, idx_d;
    logic        br_q, br_d;
    logic [15:0] diff_q, diff_d;
    logic        bout_q, bout_d;

    logic [3:0]  a_nib, b_nib, g, p, d_nib;
    logic        br_in;
    logic [4:1]  br_n;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];
    assign g     = ~a_nib & b_nib;
    assign p     = ~(a_nib ^ b_nib);
    assign br_in = (idx_q == 2'd0) ? bin_q : br_q;

    // Every borrow is a flat sum of products of g/p and the slice borrow-in.
    assign br_n[1] = g[0] | (p[0] & br_in);
    assign br_n[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_in);
    assign br_n[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & br_in);
    assign br_n[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & br_in);
    assign d_nib   = a_nib ^ b_nib ^ {br_n[3:1], br_in};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bin_d   = bin_q;
        idx_d   = idx_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = bin;
                    idx_d   = 2'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[{idx_q, 2'b00} +: 4] = d_nib;
                br_d  = br_n[4];
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    bout_d  = br_n[4];
                    state_d = DONE;
`ifdef SUB_CLAMP_EN
                    if (br_n[4]) begin
                        diff_d = 16'h0000;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bin_q   <= 1'b0;
            idx_q   <= 2'd0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = (diff_q == 16'h0000);

endmodule

// File: tb/tb_sub_serial_16b.sv
// Scoreboard bench for sub_serial_16b: the driver pushes expected results from an arithmetic
// model, and an independent monitor pops and compares them on every done pulse.
module tb_sub_serial_16b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, zero;
    logic [15:0] diff;

    sub_serial_16b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unsigned a - b - bin taken modulo 2^16; a borrow means a < b + bin.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
        exp_t r;
        int   lhs, rhs;
        lhs    = int'(x);
        rhs    = int'(y) + int'(c);
        r.bout = (lhs < rhs);
        r.diff = 16'((lhs - rhs + 65536) % 65536);
`ifdef SUB_CLAMP_EN
        if (r.bout) r.diff = 16'h0000;
`endif
        r.zero = (r.diff == 16'h0000);
        return r;
    endfunction

    // Called and returns at a falling edge; waits for IDLE, then issues one operation.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("idle_timeout", 32'(busy), 32'd0);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        sb.push_back(model(ta, tb_v, tbin));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        bin   = 1'($urandom);
        @(negedge clk);
    endtask

    // Monitor: consecutive busy samples must total 5 when done is seen.
    int   busy_run = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                check("done_has_expect", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("diff", 32'(diff), 32'(mon_e.diff));
                    check("bout", 32'(bout), 32'(mon_e.bout));
                    check("zero", 32'(zero), 32'(mon_e.zero));
                    check("latency_busy_cycles", 32'(busy_run), 32'd5);
                end
            end
            if (!busy) busy_run = 0;
        end
    end

    initial begin
        int n;
        logic [15:0] ra, rb;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // First op issued in the same step as reset release: first rising edge must accept it.
        do_op(16'h1234, 16'h0234, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b1);
        do_op(16'h00FF, 16'h00FF, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1);
        do_op(16'h0000, 16'hFFFF, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = (i % 5 == 0) ? ra : 16'($urandom);
            do_op(ra, rb, 1'($urandom));
        end

        // start held high through RUN and DONE with operands changing every cycle.
        while (busy) @(negedge clk);
        a     = 16'h5A5A;
        b     = 16'h1111;
        bin   = 1'b1;
        start = 1'b1;
        sb.push_back(model(16'h5A5A, 16'h1111, 1'b1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
        end while (busy && n < 20);
        check("reaccept_gap", 32'(n), 32'd6);
        a   = 16'h0F0F;
        b   = 16'h0F10;
        bin = 1'b0;
        sb.push_back(model(16'h0F0F, 16'h0F10, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);

        // Reset asserted during RUN cycle 2; the abandoned op must never signal done.
        while (busy) @(negedge clk);
        a     = 16'h1234;
        b     = 16'h0000;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        check("midrun_rst_diff", 32'(diff), 32'd0);
        check("midrun_rst_bout", 32'(bout), 32'd0);
        check("midrun_rst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h4321, 16'h4320, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
